// File: rtl/pio_edge_irq_pkg.sv
// Shared definitions for the edge-capturing, debounced input PIO:
// register word addresses and the read-path zero-extension helper.
package pio_edge_irq_pkg;

    localparam logic [2:0] ADDR_DATA       = 3'd0;
    localparam logic [2:0] ADDR_DEB_PERIOD = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK   = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP   = 3'd3;
    localparam logic [2:0] ADDR_RISE_EN    = 3'd4;
    localparam logic [2:0] ADDR_FALL_EN    = 3'd5;

    // Keep only the low 'w' bits of a 32-bit bus value (w in 1..32).
    function automatic logic [31:0] rd_zext(input logic [31:0] v, input int unsigned w);
        logic [31:0] mask;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        return v & mask;
    endfunction

endpackage

// File: rtl/pio_deb_bit.sv
// One input bit: multi-flop synchroniser followed by a counter-based
// debounce filter. 'q' is the accepted stable level, 'u' pulses in the
// cycle whose clock edge moves q to the new level.
module pio_deb_bit
    import pio_edge_irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             din,
    input  logic [DEB_W-1:0] period,
    output logic             q,
    output logic             u
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DEB_W-1:0]       r_cnt;
    logic                   r_q;
    logic                   w_s;
    logic                   w_diff;
    logic                   w_accept;

    // Shift the raw asynchronous input through the synchroniser chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
        end
    end

    assign w_s      = r_sync[SYNC_STAGES-1];
    assign w_diff   = (w_s != r_q);
    // '>=' rather than '==' so lowering the period mid-count still accepts
    // on the next cycle instead of waiting for the counter to wrap.
    assign w_accept = w_diff && (r_cnt >= period);

    // Count consecutive cycles where the synchronised input disagrees with q.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_q   <= 1'b0;
        end else if (!w_diff) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_q   <= w_s;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign q = r_q;
    assign u = w_accept;

endmodule

// File: rtl/pio_edge_irq_deb.sv
// Avalon-MM input PIO with per-bit synchroniser/debounce, selectable
// rising/falling edge capture (write-1-to-clear) and one level IRQ.
module pio_edge_irq_deb
    import pio_edge_irq_pkg::*;
#(
    parameter int WIDTH       = 10,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 16,
    parameter int DEB_RESET   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [DEB_W-1:0] r_period;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_cap;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [31:0]      r_readdata;

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_u;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rd;
    logic             w_wr;
    logic             w_unused_wdata;

    // Per-bit synchroniser and debounce filter.
    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        pio_deb_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_W       (DEB_W)
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (in_port[g]),
            .period  (r_period),
            .q       (w_q[g]),
            .u       (w_u[g])
        );
    end

    assign w_wr = chipselect & ~write_n;

    // An update always moves q to the opposite level, so the new level is ~q.
    assign w_set = (w_u & ~w_q & r_rise_en) | (w_u & w_q & r_fall_en);
    assign w_clr = (w_wr && (address == ADDR_EDGE_CAP)) ? writedata[WIDTH-1:0] : '0;

    // Upper write-data bits beyond the register widths are don't-care.
    assign w_unused_wdata = ^writedata;

    // Control registers written from the bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_period  <= DEB_W'(DEB_RESET);
            r_mask    <= '0;
            r_rise_en <= '1;
            r_fall_en <= '1;
        end else if (w_wr) begin
            case (address)
                ADDR_DEB_PERIOD: r_period  <= writedata[DEB_W-1:0];
                ADDR_IRQ_MASK:   r_mask    <= writedata[WIDTH-1:0];
                ADDR_RISE_EN:    r_rise_en <= writedata[WIDTH-1:0];
                ADDR_FALL_EN:    r_fall_en <= writedata[WIDTH-1:0];
                default: ;
            endcase
        end
    end

    // Edge capture: a new edge beats a same-cycle clear so no event is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cap <= '0;
        end else begin
            r_cap <= (r_cap & ~w_clr) | w_set;
        end
    end

    // Read mux, zero-extended to the bus width.
    always_comb begin
        // NOTE: default assignment first so no path leaves w_rd unassigned,
        // which would otherwise infer a latch.
        w_rd = '0;
        case (address)
            ADDR_DATA:       w_rd = rd_zext(32'(w_q),       WIDTH);
            ADDR_DEB_PERIOD: w_rd = rd_zext(32'(r_period),  DEB_W);
            ADDR_IRQ_MASK:   w_rd = rd_zext(32'(r_mask),    WIDTH);
            ADDR_EDGE_CAP:   w_rd = rd_zext(32'(r_cap),     WIDTH);
            ADDR_RISE_EN:    w_rd = rd_zext(32'(r_rise_en), WIDTH);
            ADDR_FALL_EN:    w_rd = rd_zext(32'(r_fall_en), WIDTH);
            default:         w_rd = '0;
        endcase
    end

    // Registered read data, updated every cycle regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_cap & r_mask);

endmodule

// File: tb/tb_pio_edge_irq_deb.sv
// Directed bench for pio_edge_irq_deb (WIDTH=10, SYNC_STAGES=2, DEB_W=16,
// DEB_RESET=0). Inputs change and outputs are sampled 1 ns after posedge.
module tb_pio_edge_irq_deb;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [9:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int tests_run;
    int tests_failed;

    pio_edge_irq_deb #(
        .WIDTH       (10),
        .SYNC_STAGES (2),
        .DEB_W       (16),
        .DEB_RESET   (0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address = a;
        tick(1);
        d = readdata;
    endtask

    // Hard stop in case the sequence ever stalls.
    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        tests_run    = 0;
        tests_failed = 0;
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;

        // Reset state and read latency.
        tick(3);
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        tick(1);
        address = 3'd4;
        tick(1);
        check("rst_rise_en", readdata, 32'h3FF);
        address = 3'd1;
        check("rd_latency_hold", readdata, 32'h3FF);
        tick(1);
        check("rst_deb_period", readdata, 32'h0);
        bus_read(3'd5, rd);
        check("rst_fall_en", rd, 32'h3FF);

        // Period 0: edge captured SYNC_STAGES+1 edges after the step.
        bus_write(3'd2, 32'h001);
        in_port[0] = 1'b1;
        tick(2);
        check("p0_irq_early", {31'b0, irq}, 32'h0);
        tick(1);
        check("p0_irq_set", {31'b0, irq}, 32'h1);
        bus_write(3'd3, 32'h001);
        check("p0_irq_cleared", {31'b0, irq}, 32'h0);
        bus_read(3'd0, rd);
        check("p0_data", rd, 32'h001);

        // Period 5: 4-cycle glitch rejected, 6-cycle level accepted at t+8.
        bus_write(3'd1, 32'd5);
        bus_write(3'd2, 32'h005);
        in_port[2] = 1'b1;
        tick(4);
        in_port[2] = 1'b0;
        tick(10);
        bus_read(3'd0, rd);
        check("glitch_data", rd, 32'h001);
        bus_read(3'd3, rd);
        check("glitch_cap", rd, 32'h0);
        address = 3'd0;
        in_port[2] = 1'b1;
        tick(7);
        check("deb_irq_early", {31'b0, irq}, 32'h0);
        tick(1);
        check("deb_irq_set", {31'b0, irq}, 32'h1);
        tick(1);
        check("deb_data", readdata, 32'h005);
        bus_write(3'd3, 32'h004);
        check("deb_irq_cleared", {31'b0, irq}, 32'h0);
        bus_write(3'd1, 32'd0);

        // Rising edges disabled: only the falling transition captures.
        bus_write(3'd4, 32'h000);
        bus_write(3'd2, 32'h010);
        in_port[4] = 1'b1;
        tick(6);
        check("norise_irq", {31'b0, irq}, 32'h0);
        bus_read(3'd0, rd);
        check("norise_data", rd, 32'h015);
        in_port[4] = 1'b0;
        tick(2);
        check("fall_irq_early", {31'b0, irq}, 32'h0);
        tick(1);
        check("fall_irq_set", {31'b0, irq}, 32'h1);
        bus_read(3'd3, rd);
        check("fall_cap", rd, 32'h010);
        bus_write(3'd4, 32'h3FF);
        bus_write(3'd3, 32'h010);
        bus_read(3'd3, rd);
        check("fall_cap_clear", rd, 32'h0);

        // Partial W1C and set-beats-clear on the same bit.
        in_port[2] = 1'b0;
        in_port[3] = 1'b1;
        tick(4);
        bus_read(3'd3, rd);
        check("cap_0c", rd, 32'h00C);
        bus_write(3'd3, 32'h004);
        bus_read(3'd3, rd);
        check("w1c_partial", rd, 32'h008);
        in_port[3] = 1'b0;
        tick(2);
        bus_write(3'd3, 32'h008);
        bus_read(3'd3, rd);
        check("set_beats_clear", rd, 32'h008);
        bus_write(3'd3, 32'h008);
        bus_read(3'd3, rd);
        check("cap_clear_all", rd, 32'h0);

        // Masked capture, then unmask raises irq.
        bus_write(3'd2, 32'h000);
        in_port[9] = 1'b1;
        tick(3);
        check("masked_irq", {31'b0, irq}, 32'h0);
        bus_read(3'd3, rd);
        check("masked_cap", rd, 32'h200);
        bus_write(3'd2, 32'h200);
        check("unmask_irq", {31'b0, irq}, 32'h1);
        bus_read(3'd6, rd);
        check("addr6_zero", rd, 32'h0);

        // Reset in the middle of a debounce count.
        bus_write(3'd1, 32'd5);
        in_port = '0;
        tick(4);
        reset_n = 1'b0;
        #1;
        check("midrst_irq", {31'b0, irq}, 32'h0);
        check("midrst_readdata", readdata, 32'h0);
        tick(2);
        reset_n = 1'b1;
        bus_read(3'd1, rd);
        check("midrst_period", rd, 32'h0);
        bus_read(3'd2, rd);
        check("midrst_mask", rd, 32'h0);
        bus_read(3'd3, rd);
        check("midrst_cap", rd, 32'h0);
        bus_read(3'd5, rd);
        check("midrst_fall_en", rd, 32'h3FF);
        bus_read(3'd0, rd);
        check("midrst_data", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
